// File: rtl/cms_pix28_test_scheduler_pkg.sv
// Shared types and constants for the pix28 test scheduler.
package cms_pix28_package;

  localparam int NUM_TESTS_MAX = 15;
  localparam int PIN_W         = 7;

  // Idle level of config_load: shift register presents its parallel outputs.
  localparam logic CONFIG_REG_MODE_PARALLEL_OUT = 1'b1;

  typedef enum logic [2:0] {
    SCHED_IDLE  = 3'd0,
    SCHED_ARM   = 3'd1,
    SCHED_PULSE = 3'd2,
    SCHED_RUN   = 3'd3,
    SCHED_DONE  = 3'd4,
    SCHED_ABORT = 3'd5
  } state_t_sm_test_sched;

  // Tests use phase d-2, so the config-clock period never drops below 4 cycles.
  function automatic logic [6:0] eff_delay(input logic [6:0] dly);
    return (dly < 7'd3) ? 7'd3 : dly;
  endfunction

endpackage

// File: rtl/cms_pix28_config_clk_gen.sv
// Free-running phase counter and divided config clock shared by all tests.
module cms_pix28_config_clk_gen
  import cms_pix28_package::*;
(
  input  logic       clk,
  input  logic       reset_not,
  input  logic [6:0] test_delay,
  output logic [6:0] clk_counter,
  output logic       fast_config_clk
);

  logic [6:0] w_d;
  logic [6:0] w_half;
  logic [6:0] w_cnt_nxt;
  logic [6:0] r_cnt;
  logic       r_fcc;

  assign w_d       = eff_delay(test_delay);
  assign w_half    = 7'((8'(w_d) + 8'd1) >> 1);
  // Out-of-range count (d just lowered) falls straight back to phase 0.
  assign w_cnt_nxt = (r_cnt >= w_d) ? 7'd0 : r_cnt + 7'd1;

  // Counter and clock registered together so the clock tracks the visible count.
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      r_cnt <= 7'd0;
      r_fcc <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_fcc <= (w_cnt_nxt < w_half);
    end
  end

  assign clk_counter     = r_cnt;
  assign fast_config_clk = r_fcc;

endmodule

// File: rtl/cms_pix28_test_scheduler.sv
// Sequences one selected ipX_testY state machine: arm, phase-aligned start,
// run with timeout/abort, and muxes the selected test's pins to the chip.
module cms_pix28_test_scheduler
  import cms_pix28_package::*;
#(
  parameter int NUM_TESTS = 15,
  parameter int TMO_W     = 16
) (
  input  logic                              clk,
  input  logic                              reset_not,
  input  logic [3:0]                        test_select,
  input  logic                              test_start,
  input  logic                              test_abort,
  input  logic [6:0]                        test_delay,
  input  logic [TMO_W-1:0]                  timeout_max,
  input  logic [NUM_TESTS-1:0]              test_done_i,
  input  logic [NUM_TESTS-1:0][PIN_W-1:0]   test_pins_i,
  output logic [6:0]                        clk_counter,
  output logic                              fast_config_clk,
  output logic [NUM_TESTS-1:0]              test_enable,
  output logic                              test_enable_re,
  output state_t_sm_test_sched              sched_state,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic                              err_sel,
  output logic                              o_config_clk,
  output logic                              o_reset_not,
  output logic                              o_config_in,
  output logic                              o_config_load,
  output logic                              o_vin_test_trig_out,
  output logic                              o_scan_in,
  output logic                              o_scan_load
);

  state_t_sm_test_sched r_state, w_state_nxt;
  logic [3:0]           r_sel;
  logic                 r_start_q;
  logic [TMO_W-1:0]     r_tmo;
  logic                 r_done, r_timeout, r_err_sel, r_hold;

  logic [6:0]           w_d;
  logic                 w_edge, w_sel_ok;
  logic [NUM_TESTS-1:0] w_onehot;
  logic [TMO_W-1:0]     w_tmo_inc;
  logic                 w_done_sel, w_tmo_hit;
  logic                 w_go, w_bad, w_fin, w_tmo_ab;
  logic                 w_en_on;
  logic [PIN_W-1:0]     w_pins, w_pins_out;

  cms_pix28_config_clk_gen u_clk_gen (
    .clk             (clk),
    .reset_not       (reset_not),
    .test_delay      (test_delay),
    .clk_counter     (clk_counter),
    .fast_config_clk (fast_config_clk)
  );

  assign w_d        = eff_delay(test_delay);
  assign w_edge     = test_start & ~r_start_q;
  assign w_sel_ok   = (test_select != 4'd0) && (int'(test_select) <= NUM_TESTS);
  assign w_onehot   = (r_sel == 4'd0) ? '0 : (NUM_TESTS'(1) << (r_sel - 4'd1));
  assign w_tmo_inc  = (&r_tmo) ? r_tmo : r_tmo + TMO_W'(1);
  assign w_done_sel = |(test_done_i & w_onehot);
  // Hit on the cycle that completes timeout_max RUN cycles.
  assign w_tmo_hit  = (timeout_max != '0) && (w_tmo_inc == timeout_max);

  // State register.
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) r_state <= SCHED_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state and one-cycle control strobes; done beats abort/timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_bad       = 1'b0;
    w_fin       = 1'b0;
    w_tmo_ab    = 1'b0;
    case (r_state)
      SCHED_IDLE: begin
        if (w_edge) begin
          if (w_sel_ok) begin
            w_state_nxt = SCHED_ARM;
            w_go        = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      SCHED_ARM:   if (clk_counter == w_d) w_state_nxt = SCHED_PULSE;
      SCHED_PULSE: w_state_nxt = SCHED_RUN;
      SCHED_RUN: begin
        if (w_done_sel) begin
          w_state_nxt = SCHED_DONE;
          w_fin       = 1'b1;
        end else if (test_abort || w_tmo_hit) begin
          w_state_nxt = SCHED_ABORT;
          w_tmo_ab    = w_tmo_hit;
        end
      end
      SCHED_DONE:  w_state_nxt = SCHED_IDLE;
      SCHED_ABORT: w_state_nxt = SCHED_IDLE;
      default:     w_state_nxt = SCHED_IDLE;
    endcase
  end

  // Latched select, status flags, run timer and start history.
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      r_sel     <= 4'd0;
      r_start_q <= 1'b0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err_sel <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_start_q <= test_start;
      if (w_go) begin
        r_sel     <= test_select;
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
        r_err_sel <= 1'b0;
        r_hold    <= 1'b0;
      end
      if (w_bad)    r_err_sel <= 1'b1;
      if (w_fin) begin
        r_done <= 1'b1;
        r_hold <= 1'b1;
      end
      if (w_tmo_ab) r_timeout <= 1'b1;
      if (r_state == SCHED_PULSE)    r_tmo <= '0;
      else if (r_state == SCHED_RUN) r_tmo <= w_tmo_inc;
    end
  end

  // Enable stays up after a completed run so the test keeps its status.
  assign w_en_on = (r_state == SCHED_ARM) || (r_state == SCHED_PULSE) ||
                   (r_state == SCHED_RUN) || (r_state == SCHED_DONE) ||
                   ((r_state == SCHED_IDLE) && r_hold);

  assign test_enable    = w_en_on ? w_onehot : '0;
  assign test_enable_re = (r_state == SCHED_PULSE);
  assign sched_state    = r_state;
  assign busy           = (r_state == SCHED_ARM) || (r_state == SCHED_PULSE) ||
                          (r_state == SCHED_RUN);
  assign done           = r_done;
  assign timeout        = r_timeout;
  assign err_sel        = r_err_sel;

  // One-hot AND-OR pin mux; safe chip levels whenever no test is enabled.
  always_comb begin
    w_pins = '0;
    for (int k = 0; k < NUM_TESTS; k++) begin
      if (test_enable[k]) w_pins = w_pins | test_pins_i[k];
    end
    w_pins_out = (|test_enable) ? w_pins :
                 {1'b0, 1'b1, 1'b0, CONFIG_REG_MODE_PARALLEL_OUT, 3'b000};
  end

  assign {o_config_clk, o_reset_not, o_config_in, o_config_load,
          o_vin_test_trig_out, o_scan_in, o_scan_load} = w_pins_out;

endmodule

// File: tb/tb_cms_pix28_test_scheduler.sv
// Self-checking bench for cms_pix28_test_scheduler (NUM_TESTS=4).
module tb_cms_pix28_test_scheduler;
  import cms_pix28_package::*;

  localparam int NT = 4;
  localparam int TW = 16;

  logic                   clk = 1'b0;
  logic                   reset_not = 1'b0;
  logic [3:0]             test_select = '0;
  logic                   test_start = 1'b0;
  logic                   test_abort = 1'b0;
  logic [6:0]             test_delay = 7'd9;
  logic [TW-1:0]          timeout_max = '0;
  logic [NT-1:0]          test_done_i = '0;
  logic [NT-1:0][6:0]     test_pins_i = '0;
  logic [6:0]             clk_counter;
  logic                   fast_config_clk;
  logic [NT-1:0]          test_enable;
  logic                   test_enable_re;
  state_t_sm_test_sched   sched_state;
  logic                   busy, done, timeout, err_sel;
  logic                   o_config_clk, o_reset_not, o_config_in, o_config_load;
  logic                   o_vin_test_trig_out, o_scan_in, o_scan_load;

  int n_cmp = 0;
  int n_bad = 0;

  cms_pix28_test_scheduler #(.NUM_TESTS(NT), .TMO_W(TW)) dut (
    .clk(clk), .reset_not(reset_not), .test_select(test_select),
    .test_start(test_start), .test_abort(test_abort), .test_delay(test_delay),
    .timeout_max(timeout_max), .test_done_i(test_done_i), .test_pins_i(test_pins_i),
    .clk_counter(clk_counter), .fast_config_clk(fast_config_clk),
    .test_enable(test_enable), .test_enable_re(test_enable_re),
    .sched_state(sched_state), .busy(busy), .done(done), .timeout(timeout),
    .err_sel(err_sel), .o_config_clk(o_config_clk), .o_reset_not(o_reset_not),
    .o_config_in(o_config_in), .o_config_load(o_config_load),
    .o_vin_test_trig_out(o_vin_test_trig_out), .o_scan_in(o_scan_in),
    .o_scan_load(o_scan_load)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] act_pins();
    return {o_config_clk, o_reset_not, o_config_in, o_config_load,
            o_vin_test_trig_out, o_scan_in, o_scan_load};
  endfunction

  function automatic logic [6:0] exp_pins(input bit en, input int sel);
    logic [6:0] safe;
    safe = {1'b0, 1'b1, 1'b0, CONFIG_REG_MODE_PARALLEL_OUT, 3'b000};
    return en ? test_pins_i[sel-1] : safe;
  endfunction

  function automatic logic [31:0] onehot(input int sel);
    return 32'(1) << (sel - 1);
  endfunction

  // Clock generator vectors: programmed delay -> period and high-phase length.
  typedef struct {
    logic [6:0] dly;
    int         per;
    int         hi;
  } clk_vec_t;

  clk_vec_t cv [6];

  // One complete run; expected outcome derived from the earliest terminating event.
  task automatic do_run(input int sel, input int tmax, input int done_at, input int abort_at);
    int  e, k, g;
    bit  exp_done, exp_tmo;
    int  other;
    e = 1000000;
    if (done_at  != 0)                  e = done_at;
    if (abort_at != 0 && abort_at < e)  e = abort_at;
    if (tmax     != 0 && tmax < e)      e = tmax;
    exp_done = (done_at == e);
    exp_tmo  = !exp_done && (tmax == e);
    other    = (sel % NT) + 1;

    test_select = 4'(sel); timeout_max = TW'(tmax);
    test_done_i = '0; test_abort = 1'b0; test_start = 1'b1;
    @(negedge clk);
    test_start = 1'b0;
    chk("arm_state",  32'(sched_state), 32'(SCHED_ARM));
    chk("arm_busy",   32'(busy), 32'd1);
    chk("arm_enable", 32'(test_enable), onehot(sel));
    chk("arm_flags",  32'({done, timeout, err_sel}), 32'd0);

    g = 0;
    while (!test_enable_re && g < 300) begin @(negedge clk); g++; end
    chk("re_seen",  32'(test_enable_re), 32'd1);
    chk("re_phase", 32'(clk_counter), 32'd0);

    k = 1;
    forever begin
      @(negedge clk);
      if (sched_state != SCHED_RUN || k > 1000) break;
      if (test_enable_re) chk("re_single", 32'(test_enable_re), 32'd0);
      if (k % 16 == 1) chk("run_pins", 32'(act_pins()), 32'(exp_pins(1'b1, sel)));
      if (test_enable !== NT'(onehot(sel))) chk("run_enable", 32'(test_enable), onehot(sel));
      test_pins_i = NT*7'($urandom);
      test_done_i = (done_at != 0 && k >= done_at) ? NT'(onehot(sel)) : '0;
      test_abort  = (k == abort_at);
      // Start edge and select change while busy must be ignored.
      if (k == 2) begin test_start = 1'b1; test_select = 4'(other); end
      k++;
    end
    test_start = 1'b0; test_abort = 1'b0; test_select = 4'(sel);
    chk("run_len", 32'(k - 1), 32'(e));
    chk("end_state", 32'(sched_state), exp_done ? 32'(SCHED_DONE) : 32'(SCHED_ABORT));
    chk("end_flags", 32'({done, timeout}), 32'({exp_done, exp_tmo}));
    chk("end_enable", 32'(test_enable), exp_done ? onehot(sel) : 32'd0);
    chk("end_pins", 32'(act_pins()), 32'(exp_pins(exp_done, sel)));
    @(negedge clk);
    chk("idle_state",  32'(sched_state), 32'(SCHED_IDLE));
    chk("idle_busy",   32'(busy), 32'd0);
    chk("idle_flags",  32'({done, timeout}), 32'({exp_done, exp_tmo}));
    chk("idle_enable", 32'(test_enable), exp_done ? onehot(sel) : 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_enable", 32'(test_enable), exp_done ? onehot(sel) : 32'd0);
    chk("hold_done",   32'(done), 32'(exp_done));
  endtask

  initial begin
    int g;
    cv[0] = '{7'd9,   10,  5};
    cv[1] = '{7'd1,   4,   2};
    cv[2] = '{7'd0,   4,   2};
    cv[3] = '{7'd3,   4,   2};
    cv[4] = '{7'd4,   5,   2};
    cv[5] = '{7'd127, 128, 64};

    // Reset values while held in reset.
    #1;
    chk("rst_state",  32'(sched_state), 32'(SCHED_IDLE));
    chk("rst_cnt",    32'({clk_counter, fast_config_clk}), 32'd0);
    chk("rst_enable", 32'({test_enable, test_enable_re}), 32'd0);
    chk("rst_flags",  32'({busy, done, timeout, err_sel}), 32'd0);
    chk("rst_pins",   32'(act_pins()), 32'(exp_pins(1'b0, 1)));
    repeat (3) @(negedge clk);
    reset_not = 1'b1;

    // Clock generator across delay settings.
    foreach (cv[v]) begin
      test_delay = cv[v].dly;
      g = 0;
      do begin @(negedge clk); g++; end while (clk_counter != 0 && g < 300);
      chk("cnt_sync", 32'(clk_counter), 32'd0);
      for (int i = 0; i < 2 * cv[v].per; i++) begin
        chk("clk_counter", 32'(clk_counter), 32'(i % cv[v].per));
        chk("fast_config_clk", 32'(fast_config_clk), 32'((i % cv[v].per) < cv[v].hi));
        @(negedge clk);
      end
    end
    test_delay = 7'd9;

    // Invalid selects: flag error, stay idle, no enable.
    test_select = 4'd0; test_start = 1'b1;
    @(negedge clk); test_start = 1'b0;
    chk("sel0_err",   32'(err_sel), 32'd1);
    chk("sel0_state", 32'(sched_state), 32'(SCHED_IDLE));
    chk("sel0_en",    32'(test_enable), 32'd0);
    @(negedge clk);
    test_select = 4'd15; test_start = 1'b1;
    @(negedge clk); test_start = 1'b0;
    chk("sel15_err",   32'(err_sel), 32'd1);
    chk("sel15_state", 32'(sched_state), 32'(SCHED_IDLE));
    chk("sel15_en",    32'({test_enable, busy}), 32'd0);
    @(negedge clk);

    // Directed runs: done, timeout, abort, done/timeout tie.
    do_run(1, 0, 200, 0);
    do_run(2, 50, 0, 0);
    do_run(3, 0, 0, 17);
    do_run(4, 10, 10, 0);
    do_run(1, 1, 0, 0);

    // Randomized runs against the outcome model.
    for (int r = 0; r < 10; r++) begin
      int sel, tmax, dn, ab;
      sel  = $urandom_range(1, NT);
      tmax = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
      dn   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0;
      ab   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0;
      if (tmax != 0 && ab == tmax) ab = tmax + 1;
      if (tmax == 0 && dn == 0 && ab == 0) dn = 30;
      test_delay = 7'($urandom_range(0, 20));
      do_run(sel, tmax, dn, ab);
    end
    test_delay = 7'd9;

    // Reset asserted in the middle of a run.
    test_select = 4'd3; timeout_max = '0; test_done_i = '0; test_start = 1'b1;
    @(negedge clk); test_start = 1'b0;
    g = 0;
    while (sched_state != SCHED_RUN && g < 300) begin @(negedge clk); g++; end
    chk("mid_run", 32'(sched_state), 32'(SCHED_RUN));
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    reset_not = 1'b0;
    #1;
    chk("mrst_state",  32'(sched_state), 32'(SCHED_IDLE));
    chk("mrst_enable", 32'({test_enable, test_enable_re}), 32'd0);
    chk("mrst_flags",  32'({busy, done, timeout, err_sel}), 32'd0);
    chk("mrst_cnt",    32'({clk_counter, fast_config_clk}), 32'd0);
    chk("mrst_pins",   32'(act_pins()), 32'(exp_pins(1'b0, 3)));
    @(negedge clk);
    reset_not = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
